mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one multi-cycle memory port between the pipeline's instruction fetch (read-only) and data access (read/write) requesters. Each requester uses the pipeline's existing pulse-request/pulse-response memory protocol. The arbiter captures requests, serialises them onto a single downstream port with bounded data priority, and routes each response back to its owner. It sits between the cpu top level and the unified memory model/cache.

Parameters:
MAX_CONSEC, 2, maximum consecutive dmem grants while an imem request is pending (legal range 1..7).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
imem_addr  in  32  fetch address
imem_rmask  in  4  nonzero for one cycle = fetch request
imem_rdata  out  32  fetch data, valid with imem_resp
imem_resp  out  1  one-cycle fetch completion
dmem_addr  in  32  data address
dmem_rmask  in  4  nonzero = load request
dmem_wmask  in  4  nonzero = store request
dmem_wdata  in  32  store data
dmem_rdata  out  32  load data, valid with dmem_resp
dmem_resp  out  1  one-cycle data completion
mem_addr  out  32  downstream address
mem_rmask  out  4  downstream read mask, one-cycle issue pulse
mem_wmask  out  4  downstream write mask, one-cycle issue pulse
mem_wdata  out  32  downstream store data
mem_rdata  in  32  downstream read data
mem_resp  in  1  downstream completion, at least one cycle after issue

Behaviour:
- Reset (rst=0, async): state IDLE, both pending flags 0, consec counter 0. All outputs are 0, including rdata registers and resp.
- Capture:
  - imem_rmask!=0 with i_pend=0 sets i_pend and latches addr/rmask at the clock edge.
  - dmem (rmask|wmask)!=0 with d_pend=0 sets d_pend and latches addr/rmask/wmask/wdata.
  - A request from a requester whose pend=1 is ignored; requesters must wait for their resp.
- FSM states: IDLE, WAIT_I, WAIT_D.
- IDLE, nothing pending: mem_* masks are 0, mem_addr/mem_wdata are 0.
- IDLE, one pending: that request is granted. Its latched fields drive mem_* combinationally this cycle. Next state is WAIT_I or WAIT_D.
- IDLE, both pending: imem is granted if consec>=MAX_CONSEC, otherwise dmem.
  - consec increments (saturating at 7) on each dmem grant made while i_pend=1.
  - consec clears on any imem grant, and whenever i_pend=0.
- A request captured at an edge can be issued no earlier than the following cycle; capture and issue never occur in the same cycle.
- WAIT_x: mem masks are 0, mem_addr/mem_wdata hold the granted values. The FSM waits for mem_resp.
  - On mem_resp: x_pend clears, x_rdata<=mem_rdata (stores load 0), and x_resp=1 in the next cycle only. State returns to IDLE.
  - The other requester may capture during WAIT; it is issued from IDLE.
- mem_resp in IDLE is ignored (covers stale responses after a reset).
- Latency: request edge t → issue cycle t+1 → mem_resp at t+1+L → requester resp at t+2+L.
- Back-to-back requests: a requester may issue a new request in the same cycle its resp is high; it is captured normally.
- Reset mid-WAIT: the outstanding transaction is dropped, and no resp is generated for it.
- Simultaneous imem and dmem requests in the same cycle: both are captured, and arbitration follows the rules above.

Test Plan:
- Reset then lone fetch: imem_rmask=F, addr 0x60000000; memory L=1, rdata 0x00000013 → mem_rmask=F one cycle; imem_resp pulses 3 cycles after the request with rdata 0x00000013.
- Lone store: dmem_wmask=3, addr 0x100, wdata 0xBEEF → mem_wmask=3, mem_wdata=0xBEEF one cycle; dmem_resp once; imem_resp stays 0.
- Simultaneous fetch and load, MAX_CONSEC=2 → dmem issued first, then imem; each rdata is routed to the correct requester with no swap.
- Continuous load stream with a fetch pending, MAX_CONSEC=2 → grant order D, D, I, D, D, I; the fetch completes within 3 transactions.
- Repeat fetch pulse while fetch pending → ignored; exactly one mem issue and one imem_resp.
- Assert rst low during WAIT_D, release, then return a stale mem_resp → no dmem_resp, all outputs 0, and the next fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between instruction fetch and data access.
// Data wins ties unless MAX_CONSEC data grants have already passed a waiting fetch.
module mem_port_arbiter #(
  parameter int unsigned MAX_CONSEC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);
  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  localparam logic [2:0] MAX_C = 3'(MAX_CONSEC);

  state_t      r_state;
  logic        r_i_pend;
  logic        r_d_pend;
  logic [31:0] r_i_addr;
  logic [3:0]  r_i_rmask;
  logic [31:0] r_d_addr;
  logic [3:0]  r_d_rmask;
  logic [3:0]  r_d_wmask;
  logic [31:0] r_d_wdata;
  logic [2:0]  r_consec;
  logic [31:0] r_hold_addr;
  logic [31:0] r_hold_wdata;
  logic [31:0] r_imem_rdata;
  logic [31:0] r_dmem_rdata;
  logic        r_imem_resp;
  logic        r_dmem_resp;

  logic w_idle;
  logic w_grant_i;
  logic w_grant_d;
  logic w_i_done;
  logic w_d_done;
  logic w_i_req;
  logic w_d_req;

  assign w_idle    = (r_state == IDLE);
  assign w_grant_i = w_idle && r_i_pend && (!r_d_pend || (r_consec >= MAX_C));
  assign w_grant_d = w_idle && r_d_pend && !w_grant_i;
  assign w_i_done  = (r_state == WAIT_I) && mem_resp;
  assign w_d_done  = (r_state == WAIT_D) && mem_resp;
  // Only pend flags gate capture, so a request captured now is issued next cycle at the earliest.
  assign w_i_req   = (imem_rmask != 4'd0) && !r_i_pend;
  assign w_d_req   = ((dmem_rmask | dmem_wmask) != 4'd0) && !r_d_pend;

  always_comb begin
    mem_addr  = 32'd0;
    mem_rmask = 4'd0;
    mem_wmask = 4'd0;
    mem_wdata = 32'd0;
    if (w_grant_i) begin
      mem_addr  = r_i_addr;
      mem_rmask = r_i_rmask;
    end else if (w_grant_d) begin
      mem_addr  = r_d_addr;
      mem_rmask = r_d_rmask;
      mem_wmask = r_d_wmask;
      mem_wdata = r_d_wdata;
    end else if (!w_idle) begin
      mem_addr  = r_hold_addr;
      mem_wdata = r_hold_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_i_pend     <= 1'b0;
      r_d_pend     <= 1'b0;
      r_i_addr     <= 32'd0;
      r_i_rmask    <= 4'd0;
      r_d_addr     <= 32'd0;
      r_d_rmask    <= 4'd0;
      r_d_wmask    <= 4'd0;
      r_d_wdata    <= 32'd0;
      r_consec     <= 3'd0;
      r_hold_addr  <= 32'd0;
      r_hold_wdata <= 32'd0;
      r_imem_rdata <= 32'd0;
      r_dmem_rdata <= 32'd0;
      r_imem_resp  <= 1'b0;
      r_dmem_resp  <= 1'b0;
    end else begin
      r_imem_resp <= w_i_done;
      r_dmem_resp <= w_d_done;
      if (w_i_done) r_imem_rdata <= mem_rdata;
      if (w_d_done) r_dmem_rdata <= (r_d_wmask != 4'd0) ? 32'd0 : mem_rdata;

      if (w_i_done) begin
        r_i_pend <= 1'b0;
      end else if (w_i_req) begin
        r_i_pend  <= 1'b1;
        r_i_addr  <= imem_addr;
        r_i_rmask <= imem_rmask;
      end

      if (w_d_done) begin
        r_d_pend <= 1'b0;
      end else if (w_d_req) begin
        r_d_pend  <= 1'b1;
        r_d_addr  <= dmem_addr;
        r_d_rmask <= dmem_rmask;
        r_d_wmask <= dmem_wmask;
        r_d_wdata <= dmem_wdata;
      end

      if (!r_i_pend || w_grant_i) begin
        r_consec <= 3'd0;
      end else if (w_grant_d && (r_consec != 3'd7)) begin
        r_consec <= r_consec + 3'd1;
      end

      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_state      <= WAIT_I;
            r_hold_addr  <= r_i_addr;
            r_hold_wdata <= 32'd0;
          end else if (w_grant_d) begin
            r_state      <= WAIT_D;
            r_hold_addr  <= r_d_addr;
            r_hold_wdata <= r_d_wdata;
          end
        end
        WAIT_I:  if (mem_resp) r_state <= IDLE;
        WAIT_D:  if (mem_resp) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_rdata = r_imem_rdata;
  assign imem_resp  = r_imem_resp;
  assign dmem_rdata = r_dmem_rdata;
  assign dmem_resp  = r_dmem_resp;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random phase,
// checked against a transaction-level model of the request/grant/response rules.
module tb_mem_port_arbiter;
  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr = 32'd0;
  logic [3:0]  imem_rmask = 4'd0;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr = 32'd0;
  logic [3:0]  dmem_rmask = 4'd0;
  logic [3:0]  dmem_wmask = 4'd0;
  logic [31:0] dmem_wdata = 32'd0;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_resp = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_CONSEC(MAX)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Transaction-level model: who is pending, who is waiting for a grant, who owns the port.
  bit          m_i_pend, m_d_pend, m_i_wait, m_d_wait, m_busy, m_own_d, m_own_st;
  logic [31:0] m_i_addr, m_d_addr, m_d_wdata, m_hold_addr, m_hold_wdata;
  logic [3:0]  m_i_rmask, m_d_rmask, m_d_wmask;
  int          m_streak, m_lat;
  int          lat_min = 1, lat_max = 1;
  bit          e_i_resp, e_d_resp;
  logic [31:0] e_i_rdata, e_d_rdata;
  bit          use_fix = 1'b0;
  logic [31:0] fix_data = 32'd0;
  byte         resp_q[$];
  int          i_resp_cnt = 0, d_resp_cnt = 0, issue_cnt = 0, txn_no = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    m_i_pend = 0; m_d_pend = 0; m_i_wait = 0; m_d_wait = 0;
    m_busy = 0; m_own_d = 0; m_own_st = 0; m_streak = 0; m_lat = 0;
    e_i_resp = 0; e_d_resp = 0; e_i_rdata = 0; e_d_rdata = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_imem_rdata"}, imem_rdata, 32'd0);
    chk({tag, "_imem_resp"}, imem_resp, 32'd0);
    chk({tag, "_dmem_rdata"}, dmem_rdata, 32'd0);
    chk({tag, "_dmem_resp"}, dmem_resp, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_rmask"}, mem_rmask, 32'd0);
    chk({tag, "_mem_wmask"}, mem_wmask, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  // One clock cycle: check this cycle's outputs against the model, then advance past the edge.
  task automatic cyc();
    bit          issue, exp_any, exp_d, resp_now, cap_i, cap_d;
    bit          nx_i = 0, nx_d = 0;
    logic [31:0] nx_i_rd = 0, nx_d_rd = 0;
    issue   = (mem_rmask != 4'd0) || (mem_wmask != 4'd0);
    exp_any = !m_busy && (m_i_wait || m_d_wait);
    exp_d   = m_d_wait && (!m_i_wait || (m_streak < MAX));
    chk("issue_pulse", 32'(issue), 32'(exp_any));
    if (issue) issue_cnt++;
    if (exp_any) begin
      if (exp_d) begin
        chk("d_addr", mem_addr, m_d_addr);
        chk("d_rmask", mem_rmask, m_d_rmask);
        chk("d_wmask", mem_wmask, m_d_wmask);
        chk("d_wdata", mem_wdata, m_d_wdata);
        if (m_i_wait) m_streak++;
        m_d_wait = 0; m_own_d = 1; m_own_st = (m_d_wmask != 4'd0);
        m_hold_addr = m_d_addr; m_hold_wdata = m_d_wdata;
      end else begin
        chk("i_addr", mem_addr, m_i_addr);
        chk("i_rmask", mem_rmask, m_i_rmask);
        chk("i_wmask", mem_wmask, 32'd0);
        chk("i_wdata", mem_wdata, 32'd0);
        m_streak = 0;
        m_i_wait = 0; m_own_d = 0; m_own_st = 0;
        m_hold_addr = m_i_addr; m_hold_wdata = 32'd0;
      end
      m_busy = 1;
      m_lat = int'($urandom_range(lat_max, lat_min));
      txn_no++;
      $display("txn %0d: grant %s addr=%08h rmask=%h wmask=%h wdata=%08h lat=%0d",
               txn_no, exp_d ? "D" : "I", mem_addr, mem_rmask, mem_wmask, mem_wdata, m_lat);
    end else begin
      chk("hold_addr", mem_addr, m_busy ? m_hold_addr : 32'd0);
      chk("hold_wdata", mem_wdata, m_busy ? m_hold_wdata : 32'd0);
    end

    chk("imem_resp", imem_resp, e_i_resp);
    if (e_i_resp) chk("imem_rdata", imem_rdata, e_i_rdata);
    chk("dmem_resp", dmem_resp, e_d_resp);
    if (e_d_resp) chk("dmem_rdata", dmem_rdata, e_d_rdata);
    if (imem_resp === 1'b1) begin i_resp_cnt++; resp_q.push_back("I"); end
    if (dmem_resp === 1'b1) begin d_resp_cnt++; resp_q.push_back("D"); end

    resp_now = mem_resp && m_busy;
    cap_i = (imem_rmask != 4'd0) && !m_i_pend;
    cap_d = ((dmem_rmask | dmem_wmask) != 4'd0) && !m_d_pend;
    if (resp_now) begin
      if (m_own_d) begin
        nx_d = 1; nx_d_rd = m_own_st ? 32'd0 : mem_rdata; m_d_pend = 0;
      end else begin
        nx_i = 1; nx_i_rd = mem_rdata; m_i_pend = 0;
      end
      m_busy = 0;
    end
    if (cap_i) begin
      m_i_pend = 1; m_i_wait = 1; m_i_addr = imem_addr; m_i_rmask = imem_rmask;
    end
    if (cap_d) begin
      m_d_pend = 1; m_d_wait = 1; m_d_addr = dmem_addr;
      m_d_rmask = dmem_rmask; m_d_wmask = dmem_wmask; m_d_wdata = dmem_wdata;
    end

    @(posedge clk);
    #1;
    e_i_resp = nx_i; e_i_rdata = nx_i_rd;
    e_d_resp = nx_d; e_d_rdata = nx_d_rd;
    imem_rmask = 4'd0; dmem_rmask = 4'd0; dmem_wmask = 4'd0;
    mem_resp = 1'b0;
    mem_rdata = $urandom;
    if (m_busy) begin
      m_lat--;
      if (m_lat == 0) begin
        mem_resp = 1'b1;
        if (use_fix) mem_rdata = fix_data;
      end
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    chk_all_zero(tag);
    m_clear();
    mem_resp = 1'b0; imem_rmask = 4'd0; dmem_rmask = 4'd0; dmem_wmask = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    int base_i, base_d, base_iss, pos;
    m_clear();
    @(posedge clk); #1;
    do_reset("rst0");

    // Lone fetch, memory latency 1, fixed read data.
    use_fix = 1; fix_data = 32'h0000_0013; lat_min = 1; lat_max = 1;
    base_i = i_resp_cnt; base_d = d_resp_cnt;
    imem_addr = 32'h6000_0000; imem_rmask = 4'hF;
    cyc(); cyc(); cyc();
    chk("fetch_not_yet", i_resp_cnt - base_i, 32'd0);
    cyc();
    chk("fetch_resp_at_3", i_resp_cnt - base_i, 32'd1);
    chk("fetch_rdata", imem_rdata, 32'h0000_0013);
    repeat (2) cyc();

    // Lone store: data side answers with zero read data.
    base_i = i_resp_cnt; base_d = d_resp_cnt;
    dmem_addr = 32'h0000_0100; dmem_wmask = 4'h3; dmem_wdata = 32'h0000_BEEF;
    repeat (6) cyc();
    chk("store_dresp_once", d_resp_cnt - base_d, 32'd1);
    chk("store_no_iresp", i_resp_cnt - base_i, 32'd0);
    chk("store_rdata_zero", dmem_rdata, 32'd0);

    // Simultaneous fetch and load: data first, then fetch, random latency and data.
    use_fix = 0; lat_min = 1; lat_max = 3;
    resp_q.delete();
    imem_addr = 32'h6000_0004; imem_rmask = 4'hF;
    dmem_addr = 32'h0000_0200; dmem_rmask = 4'hF;
    repeat (12) cyc();
    chk("simul_count", resp_q.size(), 32'd2);
    if (resp_q.size() == 2) begin
      chk("simul_first_D", 32'(resp_q[0]), 32'("D"));
      chk("simul_second_I", 32'(resp_q[1]), 32'("I"));
    end

    // Continuous load stream with a fetch pending.
    resp_q.delete();
    imem_addr = 32'h6000_0008; imem_rmask = 4'hF;
    for (int k = 0; k < 24; k++) begin
      dmem_addr = 32'h0000_0300 + 32'(k * 4); dmem_rmask = 4'hF;
      cyc();
    end
    dmem_rmask = 4'd0;
    repeat (10) cyc();
    pos = -1;
    for (int k = 0; k < resp_q.size(); k++) if (resp_q[k] == "I" && pos < 0) pos = k;
    chk("stream_first_D", (resp_q.size() > 0) ? 32'(resp_q[0]) : 32'd0, 32'("D"));
    chk("stream_fetch_within_3", 32'((pos >= 0) && (pos < 3)), 32'd1);

    // Repeat fetch pulses while the first is pending are ignored.
    lat_min = 3; lat_max = 3;
    base_i = i_resp_cnt; base_iss = issue_cnt;
    imem_addr = 32'h6000_0010; imem_rmask = 4'hF;
    cyc();
    imem_addr = 32'h6000_0020; imem_rmask = 4'hF;
    cyc();
    imem_addr = 32'h6000_0030; imem_rmask = 4'hF;
    cyc();
    repeat (6) cyc();
    chk("repeat_one_issue", issue_cnt - base_iss, 32'd1);
    chk("repeat_one_iresp", i_resp_cnt - base_i, 32'd1);

    // Reset during WAIT_D, then a stale mem_resp.
    lat_min = 6; lat_max = 6;
    base_d = d_resp_cnt;
    dmem_addr = 32'h0000_0400; dmem_rmask = 4'hF;
    repeat (3) cyc();
    do_reset("rst_wait");
    mem_resp = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    cyc();
    chk_all_zero("stale");
    cyc();
    chk("stale_no_dresp", d_resp_cnt - base_d, 32'd0);
    use_fix = 1; fix_data = 32'h1234_5678; lat_min = 1; lat_max = 1;
    base_i = i_resp_cnt;
    imem_addr = 32'h6000_0040; imem_rmask = 4'hF;
    repeat (5) cyc();
    chk("post_rst_fetch", i_resp_cnt - base_i, 32'd1);
    chk("post_rst_rdata", imem_rdata, 32'h1234_5678);

    // Random traffic, including pulses while pending and back-to-back requests.
    use_fix = 0; lat_min = 1; lat_max = 4;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(2, 0) == 0) begin
        imem_addr = $urandom; imem_rmask = 4'($urandom_range(15, 1));
      end
      if ($urandom_range(2, 0) == 0) begin
        dmem_addr = $urandom; dmem_wdata = $urandom;
        if ($urandom_range(1, 0) == 0) dmem_rmask = 4'($urandom_range(15, 1));
        else dmem_wmask = 4'($urandom_range(15, 1));
      end
      cyc();
    end
    repeat (12) cyc();
    chk("drain_idle_addr", mem_addr, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
